// File: rtl/block_store_arbiter_pkg.sv
// rtl/block_store_arbiter_pkg.sv - shared block-grid geometry, logic op encodings and arbiter FSM states
package block_store_arbiter_pkg;

    // Block grid geometry shared with the renderer and the game logic
    localparam int BLOCK_COLS      = 16;
    localparam int BLOCK_ROWS      = 8;
    localparam int GRID_NUM_BLOCKS = BLOCK_COLS * BLOCK_ROWS;
    localparam int BLOCK_ADDR_W    = 7;
    localparam int STARVE_MAX_WAIT = 64;

    // Logic-side operation codes; 2'b11 is reserved and behaves as a read
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_REFILL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/block_alive_ram.sv
// rtl/block_alive_ram.sv - single-port synchronous-read, read-before-write 1-bit block store
module block_alive_ram #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              wdata,
    output logic              rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic mem [0:DEPTH-1];
    logic in_range;

    assign in_range = {1'b0, addr} < DEPTH_L;

    // Old contents are returned on the same edge that writes new data; holes above DEPTH read as dead
    always_ff @(posedge clk) begin
        if (in_range) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end else begin
            rdata <= 1'b0;
        end
    end

endmodule

// File: rtl/block_store_arbiter.sv
// rtl/block_store_arbiter.sv - alive-store port arbiter (renderer / refill / logic), optional BLOCK_ARB_STARVE_GUARD_EN
module block_store_arbiter
    import block_store_arbiter_pkg::*;
#(
    parameter int NUM_BLOCKS = GRID_NUM_BLOCKS,
    parameter int ADDR_W     = BLOCK_ADDR_W,
    parameter int MAX_WAIT   = STARVE_MAX_WAIT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RENDER_ACTIVE,
    input  logic [ADDR_W-1:0] RENDER_ADDR,
    output logic              RENDER_ALIVE,
    input  logic              LOGIC_REQ,
    input  logic [1:0]        LOGIC_OP,
    input  logic [ADDR_W-1:0] LOGIC_ADDR,
    output logic              LOGIC_ACK,
    output logic              LOGIC_ALIVE,
    input  logic              REFILL_START,
    output logic              REFILL_BUSY,
    output logic              REFILL_DONE,
    output logic [ADDR_W:0]   ALIVE_COUNT
);

`ifdef BLOCK_ARB_STARVE_GUARD_EN
    localparam bit STARVE_GUARD = 1'b1;
`else
    localparam bit STARVE_GUARD = 1'b0;
`endif

    localparam int              WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_W:0] NB         = (ADDR_W + 1)'(NUM_BLOCKS);
    localparam logic [ADDR_W:0] LAST       = NB - 1'b1;

    arb_state_t        state;
    logic [ADDR_W-1:0] refill_addr;
    logic              refill_pend;
    logic              render_sel_q;
    logic              render_hold;
    logic [WAIT_W-1:0] wait_cnt;

    logic              logic_pending;
    logic              logic_grant;
    logic              render_grant;
    logic              refill_wr;
    logic              refill_last;
    logic              logic_in_range;
    logic              starve;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_wdata;
    logic              mem_rdata;

    // Port grant and memory input mux; the ACK cycle is excluded so a held request is not served twice
    always_comb begin
        logic_pending  = LOGIC_REQ && !LOGIC_ACK && (state == ST_IDLE);
        starve         = STARVE_GUARD && (wait_cnt == WAIT_LIMIT);
        logic_grant    = logic_pending && (!RENDER_ACTIVE || starve);
        render_grant   = RENDER_ACTIVE && !logic_grant;
        refill_wr      = (state == ST_REFILL) && !RENDER_ACTIVE;
        refill_last    = ({1'b0, refill_addr} == LAST);
        logic_in_range = {1'b0, LOGIC_ADDR} < NB;
        mem_addr       = RENDER_ADDR;
        mem_we         = 1'b0;
        mem_wdata      = 1'b0;
        if (logic_grant) begin
            mem_addr  = LOGIC_ADDR;
            mem_we    = logic_in_range && ((LOGIC_OP == OP_CLEAR) || (LOGIC_OP == OP_SET));
            mem_wdata = (LOGIC_OP == OP_SET);
        end else if (refill_wr) begin
            mem_addr  = refill_addr;
            mem_we    = 1'b1;
            mem_wdata = 1'b1;
        end
    end

    block_alive_ram #(
        .DEPTH  (NUM_BLOCKS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (CLK),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Read data belongs to the renderer only when it owned the port last cycle; otherwise repeat
    assign RENDER_ALIVE = render_sel_q ? mem_rdata : render_hold;

    // Starvation wait counter; saturates at the limit and only matters when the guard is built in
    always_ff @(posedge CLK) begin
        if (RESET || logic_grant) begin
            wait_cnt <= '0;
        end else if (logic_pending && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Arbiter FSM with registered handshake, refill sequencing and live-block count
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_REFILL;
            refill_addr  <= '0;
            refill_pend  <= 1'b0;
            render_sel_q <= 1'b0;
            render_hold  <= 1'b0;
            LOGIC_ACK    <= 1'b0;
            LOGIC_ALIVE  <= 1'b0;
            REFILL_BUSY  <= 1'b0;
            REFILL_DONE  <= 1'b0;
            ALIVE_COUNT  <= '0;
        end else begin
            render_sel_q <= render_grant;
            render_hold  <= RENDER_ALIVE;
            LOGIC_ACK    <= 1'b0;
            LOGIC_ALIVE  <= 1'b0;
            REFILL_DONE  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (logic_grant) begin
                        state       <= ST_SERVE;
                        refill_pend <= REFILL_START;
                        REFILL_BUSY <= REFILL_START;
                    end else if (REFILL_START) begin
                        state       <= ST_REFILL;
                        refill_addr <= '0;
                        ALIVE_COUNT <= '0;
                        REFILL_BUSY <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    LOGIC_ACK   <= 1'b1;
                    LOGIC_ALIVE <= logic_in_range && mem_rdata;
                    if (logic_in_range && (LOGIC_OP == OP_CLEAR) && mem_rdata) begin
                        ALIVE_COUNT <= ALIVE_COUNT - 1'b1;
                    end else if (logic_in_range && (LOGIC_OP == OP_SET) && !mem_rdata) begin
                        ALIVE_COUNT <= ALIVE_COUNT + 1'b1;
                    end
                    if (refill_pend || REFILL_START) begin
                        state       <= ST_REFILL;
                        refill_addr <= '0;
                        refill_pend <= 1'b0;
                        ALIVE_COUNT <= '0;
                        REFILL_BUSY <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REFILL: begin
                    REFILL_BUSY <= 1'b1;
                    if (REFILL_START) begin
                        refill_addr <= '0;
                    end else if (refill_wr) begin
                        if (refill_last) begin
                            state       <= ST_IDLE;
                            REFILL_DONE <= 1'b1;
                            REFILL_BUSY <= 1'b0;
                            ALIVE_COUNT <= NB;
                        end else begin
                            refill_addr <= refill_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_store_arbiter.sv
// tb/tb_block_store_arbiter.sv - self-checking bench for block_store_arbiter
module tb_block_store_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       render_active;
    logic [6:0] render_addr;
    logic       logic_req;
    logic [1:0] logic_op;
    logic [6:0] logic_addr;
    logic       refill_start;

    logic       render_alive, logic_ack, logic_alive, refill_busy, refill_done;
    logic [7:0] alive_count;
    logic       render_alive_s, logic_ack_s, logic_alive_s, refill_busy_s, refill_done_s;
    logic [7:0] alive_count_s;

    int checks = 0;
    int errors = 0;

    bit [127:0] m0;
    bit [127:0] m1;
    bit         req_active = 0;
    bit         got_ack = 0;
    bit [1:0]   cur_op;
    bit [6:0]   cur_addr;
    bit         chk_render = 0;
    bit         rand_render = 0;
    bit         exp_valid = 0;
    bit         exp_render = 0;
    logic       last_alive, last_alive_s;

    block_store_arbiter dut (
        .CLK(clk), .RESET(reset), .RENDER_ACTIVE(render_active), .RENDER_ADDR(render_addr),
        .RENDER_ALIVE(render_alive), .LOGIC_REQ(logic_req), .LOGIC_OP(logic_op),
        .LOGIC_ADDR(logic_addr), .LOGIC_ACK(logic_ack), .LOGIC_ALIVE(logic_alive),
        .REFILL_START(refill_start), .REFILL_BUSY(refill_busy), .REFILL_DONE(refill_done),
        .ALIVE_COUNT(alive_count)
    );

    block_store_arbiter #(.NUM_BLOCKS(100)) dut_s (
        .CLK(clk), .RESET(reset), .RENDER_ACTIVE(render_active), .RENDER_ADDR(render_addr),
        .RENDER_ALIVE(render_alive_s), .LOGIC_REQ(logic_req), .LOGIC_OP(logic_op),
        .LOGIC_ADDR(logic_addr), .LOGIC_ACK(logic_ack_s), .LOGIC_ALIVE(logic_alive_s),
        .REFILL_START(refill_start), .REFILL_BUSY(refill_busy_s), .REFILL_DONE(refill_done_s),
        .ALIVE_COUNT(alive_count_s)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit [127:0] full_model(input int nb);
        bit [127:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Reference behaviour: report old bit (0 when out of range), then apply clear/set in range
    task automatic model_op(input bit [1:0] op, input bit [6:0] a, output bit e0, output bit e1);
        e0 = m0[a];
        e1 = (a < 100) ? m1[a] : 1'b0;
        if (op == 2'b01) begin
            m0[a] = 1'b0;
            if (a < 100) m1[a] = 1'b0;
        end else if (op == 2'b10) begin
            m0[a] = 1'b1;
            if (a < 100) m1[a] = 1'b1;
        end
    endtask

    task automatic tick();
        bit       rend_d;
        bit [6:0] raddr_d;
        bit       e0, e1;
        rend_d  = render_active;
        raddr_d = render_addr;
        @(posedge clk);
        #1;
        if (logic_ack) begin
            check("ack_has_req", req_active, 1);
            model_op(cur_op, cur_addr, e0, e1);
            check("logic_alive", logic_alive, e0);
            check("alive_count", alive_count, $countones(m0));
            check("ack_small", logic_ack_s, 1);
            check("logic_alive_s", logic_alive_s, e1);
            check("alive_count_s", alive_count_s, $countones(m1));
            last_alive   = logic_alive;
            last_alive_s = logic_alive_s;
            got_ack      = 1;
            req_active   = 0;
            logic_req    = 1'b0;
        end
        if (chk_render) begin
            if (rend_d) begin
                exp_render = m0[raddr_d];
                exp_valid  = 1;
                check("render_alive", render_alive, exp_render);
            end else if (exp_valid) begin
                check("render_hold", render_alive, exp_render);
            end
        end else begin
            exp_valid = 0;
        end
        if (rand_render) begin
            render_active = 1'($urandom_range(0, 1));
            render_addr   = 7'($urandom_range(0, 127));
        end
    endtask

    task automatic start_req(input bit [1:0] op, input bit [6:0] a);
        logic_op   = op;
        logic_addr = a;
        logic_req  = 1'b1;
        cur_op     = op;
        cur_addr   = a;
        req_active = 1;
        got_ack    = 0;
    endtask

    task automatic do_logic(input bit [1:0] op, input bit [6:0] a, input int limit, output int lat);
        start_req(op, a);
        lat = 0;
        while (!got_ack && lat < limit) begin
            tick();
            lat++;
        end
        check("ack_seen", got_ack, 1);
        if (!got_ack) begin
            logic_req  = 1'b0;
            req_active = 0;
        end
    endtask

    initial begin
        int n, d0, d1, dones, lat;
        reset = 1'b1; render_active = 1'b0; render_addr = '0;
        logic_req = 1'b0; logic_op = '0; logic_addr = '0; refill_start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_render_alive", render_alive, 0);
        check("rst_ack", logic_ack, 0);
        check("rst_logic_alive", logic_alive, 0);
        check("rst_busy", refill_busy, 0);
        check("rst_done", refill_done, 0);
        check("rst_count", alive_count, 0);
        reset = 1'b0;

        // Automatic refill after reset
        n = 0; d0 = 0; d1 = 0;
        while (d0 == 0 && n < 400) begin
            tick();
            n++;
            if (n == 1) check("busy_after_reset", refill_busy, 1);
            if (refill_done_s && d1 == 0) d1 = n;
            if (refill_done) d0 = n;
        end
        check("refill_done_cycle", d0, 128);
        check("refill_done_cycle_s", d1, 100);
        check("refill_count", alive_count, 128);
        check("refill_busy_low", refill_busy, 0);
        check("refill_count_s", alive_count_s, 100);
        tick();
        check("refill_done_pulse", refill_done, 0);
        m0 = full_model(128);
        m1 = full_model(100);
        chk_render = 1;

        // Renderer latency
        do_logic(2'b01, 7'd5, 20, lat);
        check("logic_latency", lat, 2);
        render_active = 1'b1; render_addr = 7'd5;
        tick();
        check("render_addr5", render_alive, 0);
        render_addr = 7'd6;
        tick();
        check("render_addr6", render_alive, 1);
        render_active = 1'b0;
        tick();
        check("render_idle_hold", render_alive, 1);
        do_logic(2'b10, 7'd5, 20, lat);

`ifndef BLOCK_ARB_STARVE_GUARD_EN
        // Renderer always wins the port
        start_req(2'b01, 7'd10);
        render_active = 1'b1;
        for (int i = 0; i < 200; i++) begin
            render_addr = 7'($urandom_range(0, 127));
            tick();
        end
        check("prio_no_ack", got_ack, 0);
        render_active = 1'b0;
        tick();
        check("prio_no_ack_grant", got_ack, 0);
        tick();
        check("prio_ack", got_ack, 1);
        check("prio_alive", last_alive, 1);
        check("prio_count", alive_count, 127);
`else
        do_logic(2'b01, 7'd10, 20, lat);
`endif

        // Idempotence and range
        do_logic(2'b01, 7'd10, 20, lat);
        check("clear_again_alive", last_alive, 0);
        check("clear_again_count", alive_count, 127);
        do_logic(2'b10, 7'd10, 20, lat);
        check("set_alive", last_alive, 0);
        check("set_count", alive_count, 128);
        do_logic(2'b00, 7'd127, 20, lat);
        check("read127", last_alive, 1);
        check("read127_s", last_alive_s, 0);
        check("read127_count_s", alive_count_s, 100);

        // Refill restart with renderer interleaving
        chk_render = 0;
        dones = 0;
        refill_start = 1'b1; render_active = 1'b1;
        tick();
        refill_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            render_active = ~render_active;
            tick();
            if (refill_done) dones++;
        end
        refill_start = 1'b1;
        tick();
        refill_start = 1'b0;
        if (refill_done) dones++;
        check("restart_busy", refill_busy, 1);
        render_active = 1'b1;
        n = 0; d0 = 0; d1 = 0;
        while (d0 == 0 && n < 600) begin
            tick();
            n++;
            if (refill_done_s && d1 == 0) d1 = n;
            if (refill_done) begin
                dones++;
                d0 = n;
            end
            render_active = ~render_active;
        end
        check("restart_done_cycle", d0, 256);
        check("restart_done_cycle_s", d1, 200);
        check("restart_single_done", dones, 1);
        check("restart_count", alive_count, 128);
        check("restart_busy_low", refill_busy, 0);
        check("restart_count_s", alive_count_s, 100);
        render_active = 1'b0;
        m0 = full_model(128);
        m1 = full_model(100);
        tick();
        chk_render = 1;

        // Randomized traffic against the reference model
        rand_render = 1;
        for (int i = 0; i < 40; i++) begin
            do_logic(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 400, lat);
        end
        rand_render = 0;
        render_active = 1'b0;
        tick();

`ifdef BLOCK_ARB_STARVE_GUARD_EN
        // Starvation guard: forced grant drops one renderer read
        begin
            bit [6:0] a_now, a_prev;
            bit       ex;
            do_logic(2'b01, 7'd7, 20, lat);
            do_logic(2'b10, 7'd8, 20, lat);
            chk_render = 0;
            render_active = 1'b1;
            render_addr = 7'd7;
            a_prev = 7'd7;
            start_req(2'b00, 7'd20);
            n = 0; d0 = 0;
            while (d0 == 0 && n < 100) begin
                a_now = render_addr;
                tick();
                n++;
                ex = (n == 65) ? m0[a_prev] : m0[a_now];
                check("guard_render", render_alive, ex);
                if (got_ack) d0 = n;
                a_prev = a_now;
                render_addr = (render_addr == 7'd7) ? 7'd8 : 7'd7;
            end
            check("guard_ack_cycle", d0, 66);
            render_active = 1'b0;
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_store_arbiter.md
Name: block_store_arbiter

Overview:
- Owns the 1-bit-per-block "alive" store. Shares its single memory port between the game-area renderer (per-pixel block lookups) and the game logic (collision read, clear, set).
- Also sequences level refill, which sets every block alive.
- Sits between the game logic and the renderer's BLOCK_ADDR/BLOCK_ALIVE pair.
- Tracks the live-block count so the logic can detect a level clear.

Parameters:
- NUM_BLOCKS, 128, number of blocks in the store; valid addresses are 0..NUM_BLOCKS-1.
- ADDR_W, 7, width of block addresses.
- MAX_WAIT, 64, starvation-guard threshold in cycles (used only with the optional feature).

Ports:
- CLK  in  1  system clock (pixel clock domain).
- RESET  in  1  synchronous, active-high reset.
- RENDER_ACTIVE  in  1  renderer owns the port this cycle (visible game-area pixel).
- RENDER_ADDR  in  ADDR_W  block address requested by the renderer.
- RENDER_ALIVE  out  1  alive bit for the RENDER_ADDR sampled one cycle earlier.
- LOGIC_REQ  in  1  logic request; held high until LOGIC_ACK.
- LOGIC_OP  in  2  operation: 00 read, 01 clear, 10 set, 11 reserved (treated as read).
- LOGIC_ADDR  in  ADDR_W  block address for the logic request.
- LOGIC_ACK  out  1  one-cycle pulse: the request has completed.
- LOGIC_ALIVE  out  1  alive bit before the operation; valid only while LOGIC_ACK is high.
- REFILL_START  in  1  pulse: set all blocks alive.
- REFILL_BUSY  out  1  high while a refill is pending or in progress.
- REFILL_DONE  out  1  one-cycle pulse after the last block has been written.
- ALIVE_COUNT  out  ADDR_W+1  number of alive blocks.

Behaviour:
- Reset: this is a synchronous, active-high reset.
  - All outputs go to 0.
  - The FSM enters REFILL with refill address 0, and REFILL_BUSY goes high in the next cycle.
  - Store contents are not reset directly; they become valid when the automatic refill completes.
- Memory: single-port, synchronous read, read-before-write. Exactly one access per cycle.
- Port grant priority, evaluated each cycle:
  1. The renderer, whenever RENDER_ACTIVE=1.
  2. Otherwise the refill FSM, in REFILL.
  3. Otherwise the logic request, if LOGIC_REQ=1.
- Renderer path:
  - Address sampled at cycle N; RENDER_ALIVE is valid at cycle N+1.
  - When RENDER_ACTIVE=0, RENDER_ALIVE holds its last value.
- FSM states:
  - IDLE: on LOGIC_REQ with the port free, go to SERVE. On REFILL_START, go to REFILL.
  - SERVE: one-cycle state. The access is issued on the grant cycle. LOGIC_ACK and LOGIC_ALIVE (old value) are asserted in the following cycle. Then return to IDLE.
  - REFILL: writes 1 to the refill address on every cycle the renderer does not own the port, then increments the address. After address NUM_BLOCKS-1 is written:
    - ALIVE_COUNT is set to NUM_BLOCKS;
    - REFILL_DONE pulses for one cycle;
    - REFILL_BUSY falls;
    - the FSM returns to IDLE.
- ALIVE_COUNT updates:
  - Clear of an alive block: decrement.
  - Set of a dead block: increment.
  - Otherwise: unchanged.
  - Forced to 0 at REFILL entry.
  - The count never underflows or overflows by construction.
- Logic request rules:
  - LOGIC_REQ, LOGIC_OP and LOGIC_ADDR must stay stable until LOGIC_ACK.
  - A new request may start the cycle after LOGIC_ACK.
  - LOGIC_REQ is stalled (no ACK) while REFILL_BUSY=1.
- Out-of-range LOGIC_ADDR (>= NUM_BLOCKS): acked with the normal timing, LOGIC_ALIVE=0, no write, count unchanged.
- REFILL_START timing:
  - Arrives during SERVE: it is latched and REFILL is entered after the ACK.
  - Arrives during REFILL: the refill address restarts at 0 and ALIVE_COUNT stays 0.
- A REFILL_START arriving in the same cycle as the grant of a logic request: the logic request completes first.
- Clear and set are idempotent: the old value is still reported on LOGIC_ALIVE.

Optional Feature:
- Macro: BLOCK_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A wait counter increments on each cycle LOGIC_REQ is pending without a grant.
  - When the counter reaches MAX_WAIT, the logic access is granted even though RENDER_ACTIVE=1.
  - That cycle's renderer read is dropped, and RENDER_ALIVE repeats its previous value.
  - The counter clears on grant.
  - Refill never preempts the renderer, with or without the macro.
- Without the macro: the renderer always wins the port, and logic requests wait indefinitely while RENDER_ACTIVE=1.

Decomposition:
- NUM_BLOCKS and the block-grid geometry live in the shared game-geometry include.
- The LOGIC_OP encodings (OP_READ, OP_CLEAR, OP_SET) and the FSM state localparams are added to that same include, so the game logic can use them.
- One sub-module: block_alive_ram, a single-port, synchronous-read, read-before-write NUM_BLOCKS x 1 memory.

Test Plan:
- Reset refill:
  - Stimulus: RESET for 1 cycle, RENDER_ACTIVE=0.
  - Response: REFILL_DONE pulses exactly 128 cycles after reset release; then ALIVE_COUNT=128 and REFILL_BUSY=0.
- Renderer latency:
  - Stimulus: after refill, clear block 5, then RENDER_ACTIVE=1 with RENDER_ADDR=5 at cycle N.
  - Response: RENDER_ALIVE=0 at N+1. RENDER_ADDR=6 then gives 1 one cycle later.
- Render priority:
  - Stimulus: LOGIC_REQ clear addr 10 while RENDER_ACTIVE=1 for 200 cycles (no guard).
  - Response: no ACK during those cycles. ACK arrives 2 cycles after RENDER_ACTIVE falls, with LOGIC_ALIVE=1 and ALIVE_COUNT=127.
- Idempotence and range:
  - Stimulus: clear 10 again, then set 10, then read addr 127, then read addr 127 with NUM_BLOCKS=100.
  - Response, in order:
    - clear 10 again: LOGIC_ALIVE=0, count stays 127;
    - set 10: LOGIC_ALIVE=0, count becomes 128;
    - read 127: LOGIC_ALIVE=1;
    - read 127 with NUM_BLOCKS=100: LOGIC_ALIVE=0, no count change.
- Refill restart:
  - Stimulus: REFILL_START, then a second REFILL_START 50 cycles later, with RENDER_ACTIVE toggling 1-on/1-off.
  - Response: a single REFILL_DONE, 256 cycles after the second start (128 writes interleaved with 128 render cycles); ALIVE_COUNT=128.
- Starvation guard (BLOCK_ARB_STARVE_GUARD_EN, MAX_WAIT=64):
  - Stimulus: LOGIC_REQ read held while RENDER_ACTIVE=1 continuously.
  - Response: grant after 64 waiting cycles, ACK on the next cycle, and RENDER_ALIVE holds its prior value for exactly one cycle.
